// File: rtl/aes_gcm_ghash_stage.sv
// aes_gcm_ghash_stage: last stage of the AES-GCM pipeline.
// Takes the encrypted H, E(J0) and E(CB) from the final AES round together
// with the carried-forward plaintext, AAD and message size. It produces the
// ciphertext (PT ^ E(CB)), folds AAD, ciphertext and length blocks into GHASH
// with an iterative GF(2^128) multiplier, and emits tag = GHASH ^ E(J0).
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   i_valid / o_ready      beat handshake (o_ready only while idle)
//   i_new_instance         first beat of a message (restarts GHASH)
//   i_last                 final beat of a message (length block + tag)
//   i_aad_valid, i_aad     optional AAD block
//   i_pt_valid, i_plain_text optional plaintext block
//   i_h, i_encrypted_j0, i_instance_size  latched on i_new_instance beats
//   i_encrypted_cb         keystream block for this beat
//   o_cipher_valid/_text   one-cycle ciphertext pulse
//   o_tag_valid/o_tag      one-cycle tag pulse, o_tag holds afterwards
module aes_gcm_ghash_stage #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_new_instance,
  input  logic         i_last,
  input  logic         i_aad_valid,
  input  logic         i_pt_valid,
  input  logic [0:127] i_aad,
  input  logic [0:127] i_plain_text,
  input  logic [0:127] i_h,
  input  logic [0:127] i_encrypted_j0,
  input  logic [0:127] i_encrypted_cb,
  input  logic [0:127] i_instance_size,
  output logic         o_cipher_valid,
  output logic [0:127] o_cipher_text,
  output logic         o_tag_valid,
  output logic [0:127] o_tag
);

  localparam int unsigned MUL_CYCLES = 128 / BITS_PER_CYCLE;
  localparam logic [6:0]  CNT_LOAD   = 7'(MUL_CYCLES - 1);
  // Reduction constant: 0xE1 in the first byte, zeros elsewhere.
  localparam logic [0:127] R_POLY    = {8'he1, 120'h0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_AAD,
    S_MUL_CT,
    S_LEN,
    S_TAG
  } state_e;

  state_e       state_q;
  logic         ready_q;
  logic [0:127] x_q;
  logic [0:127] h_q;
  logic [0:127] j0_q;
  logic [0:127] size_q;
  logic [0:127] ct_q;
  logic         pt_valid_q;
  logic         last_q;
  logic [0:127] z_q;
  logic [0:127] v_q;
  logic [0:127] y_q;
  logic [6:0]   cnt_q;
  logic         cipher_valid_q;
  logic [0:127] cipher_text_q;
  logic         tag_valid_q;
  logic [0:127] tag_q;

  logic         accept;
  logic         mul_done;
  logic [0:127] acc_x;
  logic [0:127] acc_h;
  logic [0:127] acc_size;
  logic [0:127] acc_ct;
  logic [0:127] acc_operand;
  logic [0:127] z_d;
  logic [0:127] v_d;
  logic [0:127] y_d;

  // ready_q is only ever set while idle, so it doubles as the idle qualifier.
  assign accept   = i_valid & ready_q;
  assign mul_done = (cnt_q == 7'd0);

  // Values seen by an accepted beat: a new instance starts from a cleared
  // hash and its own H/size; continuation beats use the latched copies.
  always_comb begin
    acc_x    = i_new_instance ? '0 : x_q;
    acc_h    = i_new_instance ? i_h : h_q;
    acc_size = i_new_instance ? i_instance_size : size_q;
    acc_ct   = i_plain_text ^ i_encrypted_cb;
    if (i_aad_valid) begin
      acc_operand = acc_x ^ i_aad;
    end else if (i_pt_valid) begin
      acc_operand = acc_x ^ acc_ct;
    end else begin
      acc_operand = acc_x ^ acc_size;
    end
  end

  // BITS_PER_CYCLE unrolled steps of the shift-and-add GF(2^128) multiply.
  // Y is shifted toward index 0 so the next operand bits are always at [0+].
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      if (y_q[7'(b)]) begin
        z_d = z_d ^ v_d;
      end
      if (v_d[127]) begin
        v_d = (v_d >> 1) ^ R_POLY;
      end else begin
        v_d = v_d >> 1;
      end
    end
    y_d = y_q << BITS_PER_CYCLE;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ready_q        <= 1'b0;
      x_q            <= '0;
      h_q            <= '0;
      j0_q           <= '0;
      size_q         <= '0;
      ct_q           <= '0;
      pt_valid_q     <= 1'b0;
      last_q         <= 1'b0;
      z_q            <= '0;
      v_q            <= '0;
      y_q            <= '0;
      cnt_q          <= 7'd0;
      cipher_valid_q <= 1'b0;
      cipher_text_q  <= '0;
      tag_valid_q    <= 1'b0;
      tag_q          <= '0;
    end else begin
      cipher_valid_q <= 1'b0;
      tag_valid_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (i_new_instance) begin
              h_q    <= i_h;
              j0_q   <= i_encrypted_j0;
              size_q <= i_instance_size;
            end
            x_q        <= acc_x;
            ct_q       <= acc_ct;
            pt_valid_q <= i_pt_valid;
            last_q     <= i_last;
            if (i_pt_valid) begin
              cipher_valid_q <= 1'b1;
              cipher_text_q  <= acc_ct;
            end
            z_q   <= '0;
            v_q   <= acc_h;
            y_q   <= acc_operand;
            cnt_q <= CNT_LOAD;
            if (i_aad_valid) begin
              state_q <= S_MUL_AAD;
              ready_q <= 1'b0;
            end else if (i_pt_valid) begin
              state_q <= S_MUL_CT;
              ready_q <= 1'b0;
            end else if (i_last) begin
              state_q <= S_LEN;
              ready_q <= 1'b0;
            end
          end
        end

        S_MUL_AAD: begin
          z_q   <= z_d;
          v_q   <= v_d;
          y_q   <= y_d;
          cnt_q <= cnt_q - 7'd1;
          if (mul_done) begin
            // Chain straight into the next multiply without an idle cycle.
            x_q   <= z_d;
            z_q   <= '0;
            v_q   <= h_q;
            cnt_q <= CNT_LOAD;
            if (pt_valid_q) begin
              y_q     <= z_d ^ ct_q;
              state_q <= S_MUL_CT;
            end else if (last_q) begin
              y_q     <= z_d ^ size_q;
              state_q <= S_LEN;
            end else begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
            end
          end
        end

        S_MUL_CT: begin
          z_q   <= z_d;
          v_q   <= v_d;
          y_q   <= y_d;
          cnt_q <= cnt_q - 7'd1;
          if (mul_done) begin
            x_q   <= z_d;
            z_q   <= '0;
            v_q   <= h_q;
            cnt_q <= CNT_LOAD;
            if (last_q) begin
              y_q     <= z_d ^ size_q;
              state_q <= S_LEN;
            end else begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
            end
          end
        end

        S_LEN: begin
          z_q   <= z_d;
          v_q   <= v_d;
          y_q   <= y_d;
          cnt_q <= cnt_q - 7'd1;
          if (mul_done) begin
            // Tag is registered here so it is visible during S_TAG.
            x_q         <= z_d;
            tag_q       <= z_d ^ j0_q;
            tag_valid_q <= 1'b1;
            state_q     <= S_TAG;
          end
        end

        S_TAG: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready        = ready_q;
  assign o_cipher_valid = cipher_valid_q;
  assign o_cipher_text  = cipher_text_q;
  assign o_tag_valid    = tag_valid_q;
  assign o_tag          = tag_q;

endmodule

// File: tb/tb_aes_gcm_ghash_stage.sv
// Testbench for aes_gcm_ghash_stage: table of beats plus hand sequences for
// backpressure, abandon and reset-in-LEN; outputs checked via scoreboards.
module tb_aes_gcm_ghash_stage;

  localparam int unsigned BPC = 8;
  localparam int M = 128 / BPC;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic         i_new_instance;
  logic         i_last;
  logic         i_aad_valid;
  logic         i_pt_valid;
  logic [0:127] i_aad;
  logic [0:127] i_plain_text;
  logic [0:127] i_h;
  logic [0:127] i_encrypted_j0;
  logic [0:127] i_encrypted_cb;
  logic [0:127] i_instance_size;
  logic         o_cipher_valid;
  logic [0:127] o_cipher_text;
  logic         o_tag_valid;
  logic [0:127] o_tag;

  always #5 clk = ~clk;

  aes_gcm_ghash_stage #(.BITS_PER_CYCLE(BPC)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_new_instance  (i_new_instance),
    .i_last          (i_last),
    .i_aad_valid     (i_aad_valid),
    .i_pt_valid      (i_pt_valid),
    .i_aad           (i_aad),
    .i_plain_text    (i_plain_text),
    .i_h             (i_h),
    .i_encrypted_j0  (i_encrypted_j0),
    .i_encrypted_cb  (i_encrypted_cb),
    .i_instance_size (i_instance_size),
    .o_cipher_valid  (o_cipher_valid),
    .o_cipher_text   (o_cipher_text),
    .o_tag_valid     (o_tag_valid),
    .o_tag           (o_tag)
  );

  typedef struct {
    logic         ni;
    logic         last;
    logic         aadv;
    logic         ptv;
    logic [0:127] aad;
    logic [0:127] pt;
    logic [0:127] h;
    logic [0:127] j0;
    logic [0:127] cb;
    logic [0:127] size;
    logic         has_exp;
    logic [0:127] exp_ct;
    logic [0:127] exp_tag;
  } vec_t;

  typedef struct {
    logic [0:127] val;
    int           cyc;
  } exp_t;

  exp_t ct_sb[$];
  exp_t tag_sb[$];
  vec_t vecs[10];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [0:127] m_x, m_h, m_j0, m_size;

  localparam logic [0:127] H1   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [0:127] J01  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [0:127] CB2  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [0:127] TAG2 = 128'hab6e47d42cec13bdf53a67b21257bddf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [0:127] act, input logic [0:127] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Carry-less polynomial product reduced mod x^128 + x^7 + x^2 + x + 1,
  // with element bit i holding the coefficient of x^i.
  function automatic logic [0:127] gf_mul(input logic [0:127] a, input logic [0:127] b);
    logic [0:254] p;
    logic [0:254] rmask;
    logic [0:254] bext;
    p = '0;
    rmask = '0;
    rmask[0] = 1'b1;
    rmask[1] = 1'b1;
    rmask[2] = 1'b1;
    rmask[7] = 1'b1;
    rmask[128] = 1'b1;
    bext = {b, 127'b0};
    for (int i = 0; i < 128; i++) begin
      if (a[7'(i)]) p = p ^ (bext >> i);
    end
    for (int k = 254; k >= 128; k--) begin
      if (p[8'(k)]) p = p ^ (rmask >> (k - 128));
    end
    return p[0:127];
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic vec_t mk(input logic ni, input logic last, input logic aadv, input logic ptv,
                              input logic [0:127] aad, input logic [0:127] pt,
                              input logic [0:127] h, input logic [0:127] j0,
                              input logic [0:127] cb, input logic [0:127] size,
                              input logic has_exp, input logic [0:127] exp_ct,
                              input logic [0:127] exp_tag);
    vec_t v;
    v.ni = ni; v.last = last; v.aadv = aadv; v.ptv = ptv;
    v.aad = aad; v.pt = pt; v.h = h; v.j0 = j0; v.cb = cb; v.size = size;
    v.has_exp = has_exp; v.exp_ct = exp_ct; v.exp_tag = exp_tag;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    i_new_instance  = v.ni;
    i_last          = v.last;
    i_aad_valid     = v.aadv;
    i_pt_valid      = v.ptv;
    i_aad           = v.aad;
    i_plain_text    = v.pt;
    i_h             = v.h;
    i_encrypted_j0  = v.j0;
    i_encrypted_cb  = v.cb;
    i_instance_size = v.size;
  endtask

  // Reference model: advances GHASH state and queues expected outputs for a
  // beat accepted so that its first post-acceptance cycle is acc_cyc.
  task automatic model_beat(input vec_t v, input int acc_cyc, input bit want_tag);
    logic [0:127] ct;
    logic [0:127] tag;
    exp_t e;
    int k;
    ct = v.pt ^ v.cb;
    k = 0;
    if (v.ni) begin
      m_x = '0; m_h = v.h; m_j0 = v.j0; m_size = v.size;
    end
    if (v.ptv) begin
      e.val = v.has_exp ? v.exp_ct : ct;
      e.cyc = acc_cyc;
      ct_sb.push_back(e);
    end
    if (v.aadv) begin
      m_x = gf_mul(m_x ^ v.aad, m_h);
      k++;
    end
    if (v.ptv) begin
      m_x = gf_mul(m_x ^ ct, m_h);
      k++;
    end
    if (v.last) begin
      m_x = gf_mul(m_x ^ m_size, m_h);
      tag = v.has_exp ? v.exp_tag : (m_x ^ m_j0);
      if (want_tag) begin
        e.val = tag;
        e.cyc = acc_cyc + (k + 1) * M;
        tag_sb.push_back(e);
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!o_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    ok = o_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
  endtask

  task automatic send(input vec_t v, input bit want_tag);
    bit ok;
    @(negedge clk);
    wait_ready(ok);
    if (ok) begin
      drive(v);
      i_valid = 1'b1;
      model_beat(v, cyc + 1, want_tag);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((ct_sb.size() != 0 || tag_sb.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 128'(ct_sb.size() + tag_sb.size()), 128'(0));
    repeat (3) @(negedge clk);
  endtask

  // Output monitor: compare every pulse against the scoreboard heads.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (o_tag_valid || o_cipher_valid) begin
        checks++;
        errors++;
        $display("FAIL valid_in_reset got=1 exp=0");
      end
    end else begin
      if (o_cipher_valid) begin
        if (ct_sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cipher got=%h exp=none", o_cipher_text);
        end else begin
          e = ct_sb.pop_front();
          check("cipher_text", o_cipher_text, e.val);
          check("cipher_cycle", 128'(cyc), 128'(e.cyc));
        end
      end
      if (o_tag_valid) begin
        if (tag_sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tag got=%h exp=none", o_tag);
        end else begin
          e = tag_sb.pop_front();
          check("tag", o_tag, e.val);
          check("tag_cycle", 128'(cyc), 128'(e.cyc));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v1, v2;
    bit ok;
    int a1;
    int n;

    rst = 1'b1;
    i_valid = 1'b0;
    drive(mk(0, 0, 0, 0, '0, '0, '0, '0, '0, '0, 0, '0, '0));
    repeat (3) @(negedge clk);
    check("rst_ready", 128'(o_ready), 128'(0));
    check("rst_tag", o_tag, '0);
    check("rst_ct", o_cipher_text, '0);
    check("rst_tag_valid", 128'(o_tag_valid), 128'(0));
    check("rst_ct_valid", 128'(o_cipher_valid), 128'(0));
    rst = 1'b0;

    // Beat table: known-answer GCM cases, then model-checked messages.
    // Continuation beats carry random H/J0/size that must be ignored.
    vecs[0] = mk(1, 1, 0, 0, '0, '0, H1, J01, '0, '0, 1, '0, J01);
    vecs[1] = mk(1, 1, 0, 1, '0, '0, H1, J01, CB2, 128'h80, 1, CB2, TAG2);
    vecs[2] = mk(1, 0, 1, 0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(),
                 {64'd128, 64'd128}, 0, '0, '0);
    vecs[3] = mk(0, 1, 0, 1, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(),
                 rnd128(), 0, '0, '0);
    vecs[4] = mk(1, 0, 1, 1, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(),
                 {64'd128, 64'd256}, 0, '0, '0);
    vecs[5] = mk(0, 0, 0, 1, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(),
                 rnd128(), 0, '0, '0);
    vecs[6] = mk(0, 1, 0, 0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(),
                 rnd128(), 0, '0, '0);
    vecs[7] = mk(1, 0, 1, 0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(),
                 {64'd256, 64'd128}, 0, '0, '0);
    vecs[8] = mk(0, 0, 0, 0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(),
                 rnd128(), 0, '0, '0);
    vecs[9] = mk(0, 1, 1, 1, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(),
                 rnd128(), 0, '0, '0);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i], 1'b1);
    end
    drain();

    // Backpressure: second beat held valid while the first multiplies.
    v1 = mk(1, 0, 1, 0, rnd128(), '0, rnd128(), rnd128(), '0, {64'd128, 64'd128}, 0, '0, '0);
    v2 = mk(0, 1, 0, 1, '0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 0, '0, '0);
    @(negedge clk);
    wait_ready(ok);
    if (ok) begin
      drive(v1);
      i_valid = 1'b1;
      a1 = cyc + 1;
      model_beat(v1, a1, 1'b1);
      @(posedge clk);
      #1;
      drive(v2);
      model_beat(v2, a1 + M + 1, 1'b1);
      @(negedge clk);
      check("bp_busy", 128'(o_ready), 128'(0));
      wait_ready(ok);
      check("bp_ready_cycle", 128'(cyc), 128'(a1 + M));
      @(posedge clk);
      #1;
      i_valid = 1'b0;
    end
    drain();

    // AAD+PT non-last beat: ready returns after two multiplies.
    v1 = mk(1, 0, 1, 1, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(),
            {64'd128, 64'd128}, 0, '0, '0);
    @(negedge clk);
    wait_ready(ok);
    if (ok) begin
      drive(v1);
      i_valid = 1'b1;
      a1 = cyc + 1;
      model_beat(v1, a1, 1'b1);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      @(negedge clk);
      wait_ready(ok);
      check("aadpt_ready_cycle", 128'(cyc), 128'(a1 + 2 * M));
    end
    send(mk(0, 1, 0, 0, '0, '0, '0, '0, '0, '0, 0, '0, '0), 1'b1);
    drain();

    // Abandon: a new instance replaces an unfinished message.
    send(mk(1, 0, 1, 0, rnd128(), '0, rnd128(), rnd128(), '0, rnd128(), 0, '0, '0), 1'b1);
    send(mk(1, 1, 0, 1, '0, rnd128(), rnd128(), rnd128(), rnd128(),
            {64'd0, 64'd128}, 0, '0, '0), 1'b1);
    drain();

    // Reset while in the length multiply, then rerun TC2.
    send(vecs[1], 1'b0);
    a1 = cyc;
    n = 0;
    while (cyc < a1 + M + M / 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst = 1'b1;
    #1;
    check("midlen_ready", 128'(o_ready), 128'(0));
    check("midlen_tag", o_tag, '0);
    check("midlen_tag_valid", 128'(o_tag_valid), 128'(0));
    check("midlen_ct", o_cipher_text, '0);
    check("midlen_ct_valid", 128'(o_cipher_valid), 128'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(vecs[1], 1'b1);
    drain();

    check("sb_empty", 128'(ct_sb.size() + tag_sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
